// File: rtl/xfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xfer_sequencer_pkg
// Description : State encodings, control-word layout and the state-to-control
//               decode shared by the A->B transfer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package xfer_sequencer_pkg;

    localparam int A_DEPTH_DEFAULT = 8;
    localparam int B_DEPTH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT   = 3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_FILL   = 4'd2,
        ST_REWIND = 4'd3,
        ST_OP0    = 4'd4,
        ST_OP1    = 4'd5,
        ST_OP2    = 4'd6,
        ST_DONE   = 4'd7,
        ST_ABORT  = 4'd8
    } state_e;

    typedef struct packed {
        logic in_ready;
        logic inc_a;
        logic clr_a;
        logic we_b;
        logic clr_b;
        logic alu_ld;
        logic busy;
        logic done;
        logic aborted;
    } ctrl_t;

    // Moore strobes for a state; the FILL-time write/increment is added at the top.
    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t c;
        c      = '0;
        c.busy = (st != ST_IDLE);
        case (st)
            ST_START: begin
                c.clr_a = 1'b1;
                c.clr_b = 1'b1;
            end
            ST_FILL:   c.in_ready = 1'b1;
            ST_REWIND: c.clr_a    = 1'b1;
            ST_OP0:    c.inc_a    = 1'b1;
            ST_OP1: begin
                c.inc_a  = 1'b1;
                c.alu_ld = 1'b1;
            end
            ST_OP2:    c.we_b     = 1'b1;
            ST_DONE:   c.done     = 1'b1;
            ST_ABORT: begin
                c.clr_a   = 1'b1;
                c.clr_b   = 1'b1;
                c.aborted = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic is_abortable(input state_e st);
        return (st == ST_START)  || (st == ST_FILL) || (st == ST_REWIND) ||
               (st == ST_OP0)    || (st == ST_OP1)  || (st == ST_OP2);
    endfunction

endpackage : xfer_sequencer_pkg
`default_nettype wire

// File: rtl/xfer_sequencer_counter.sv
`default_nettype none
// ============================================================================
// Module      : xfer_sequencer_counter
// Description : Saturating up-counter with synchronous clear and terminal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module xfer_sequencer_counter
    import xfer_sequencer_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT,
    parameter int MAX   = A_DEPTH_DEFAULT - 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_max_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_max_o = (count_q == WIDTH'(MAX));
    assign count_o  = count_q;

    // Holding at MAX keeps the count meaningful until the next clear.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !at_max_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : xfer_sequencer_counter
`default_nettype wire

// File: rtl/xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xfer_sequencer
// Description : Start/done/abort-controlled sequencer for one MemoryA fill
//               followed by pairwise ALU folding into MemoryB.
// Revision    : 1.0 - initial release
// ============================================================================
module xfer_sequencer
    import xfer_sequencer_pkg::*;
#(
    parameter int A_DEPTH = A_DEPTH_DEFAULT,
    parameter int B_DEPTH = B_DEPTH_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic abort_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    output logic incA_o,
    output logic weA_o,
    output logic clrA_o,
    output logic incB_o,
    output logic weB_o,
    output logic clrB_o,
    output logic alu_ld_o,
    output logic busy_o,
    output logic done_o,
    output logic aborted_o
);

    localparam int PAIR_W = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;

    state_e           state_q;
    state_e           state_d;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;

    logic             w_accept;
    logic             w_fill_last;
    logic             w_pair_last;
    logic [CNT_W-1:0] w_fill_cnt;
    logic [PAIR_W-1:0] w_pair_cnt;
    logic             w_unused;

    // in_ready is registered from the state, so an accept needs only in_valid.
    assign w_accept = in_valid_i & ctrl_q.in_ready;

    xfer_sequencer_counter #(
        .WIDTH (CNT_W),
        .MAX   (A_DEPTH - 1)
    ) u_fill_cnt (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .inc_i    (w_accept),
        .clr_i    (state_q == ST_START),
        .count_o  (w_fill_cnt),
        .at_max_o (w_fill_last)
    );

    xfer_sequencer_counter #(
        .WIDTH (PAIR_W),
        .MAX   (B_DEPTH - 1)
    ) u_pair_cnt (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .inc_i    ((state_q == ST_OP2) && !w_pair_last),
        .clr_i    (state_q == ST_REWIND),
        .count_o  (w_pair_cnt),
        .at_max_o (w_pair_last)
    );

    assign w_unused = ^{w_fill_cnt, w_pair_cnt};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i && !abort_i) state_d = ST_START;
            ST_START:  state_d = ST_FILL;
            ST_FILL:   if (w_accept && w_fill_last) state_d = ST_REWIND;
            ST_REWIND: state_d = ST_OP0;
            ST_OP0:    state_d = ST_OP1;
            ST_OP1:    state_d = ST_OP2;
            ST_OP2:    state_d = w_pair_last ? ST_DONE : ST_OP0;
            ST_DONE:   state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_i && is_abortable(state_q)) begin
            state_d = ST_ABORT;
        end
    end

    // Strobes are decoded from the next state so they line up with state_q.
    always_comb begin
        ctrl_d = decode_ctrl(state_d);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign in_ready_o = ctrl_q.in_ready;
    assign weA_o      = w_accept;
    assign incA_o     = ctrl_q.inc_a | w_accept;
    assign clrA_o     = ctrl_q.clr_a;
    assign incB_o     = ctrl_q.we_b;
    assign weB_o      = ctrl_q.we_b;
    assign clrB_o     = ctrl_q.clr_b;
    assign alu_ld_o   = ctrl_q.alu_ld;
    assign busy_o     = ctrl_q.busy;
    assign done_o     = ctrl_q.done;
    assign aborted_o  = ctrl_q.aborted;

endmodule : xfer_sequencer
`default_nettype wire

// File: tb/tb_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xfer_sequencer
// Description : Directed self-checking bench for xfer_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xfer_sequencer;

    logic clock_i = 1'b0;
    logic reset_i, start_i, abort_i, in_valid_i;
    logic in_ready_o, incA_o, weA_o, clrA_o, incB_o, weB_o, clrB_o;
    logic alu_ld_o, busy_o, done_o, aborted_o;
    logic [10:0] w_outs;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2:0] tb_addr_b;
    logic [2:0] wb_addr[$];

    xfer_sequencer dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .incA_o     (incA_o),
        .weA_o      (weA_o),
        .clrA_o     (clrA_o),
        .incB_o     (incB_o),
        .weB_o      (weB_o),
        .clrB_o     (clrB_o),
        .alu_ld_o   (alu_ld_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .aborted_o  (aborted_o)
    );

    assign w_outs = {in_ready_o, incA_o, weA_o, clrA_o, incB_o, weB_o,
                     clrB_o, alu_ld_o, busy_o, done_o, aborted_o};

    always #5 clock_i = ~clock_i;

    // counterB model: gives the MemoryB address each weB lands on.
    always @(posedge clock_i) begin
        if (reset_i || clrB_o) tb_addr_b <= 3'd0;
        else if (incB_o)       tb_addr_b <= tb_addr_b + 3'd1;
    end

    task automatic nxt();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        logic found;
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0;
        nxt(); nxt();
        reset_i = 1'b0;
        #2;
        n_cmp++;
        if (w_outs !== 11'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", w_outs, 11'h0);
        end
        nxt();
        start_i = 1'b1;
        nxt();
        start_i = 1'b0; in_valid_i = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            #2;
            if (alu_ld_o === 1'b1) found = 1'b1;
            else nxt();
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL reset_reach_op1: got %b want 1", found);
        end
        reset_i = 1'b1;
        nxt();
        #2;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_midop1_busy: got %b want 0", busy_o);
        end
        nxt();
        reset_i = 1'b0;
        #2;
        n_cmp++;
        if (w_outs !== 11'h0) begin
            n_fail++; $display("FAIL reset_midop1_outputs: got %b want %b", w_outs, 11'h0);
        end
        nxt();
        in_valid_i = 1'b0;
        #2;
        n_cmp++;
        if (w_outs !== 11'h0) begin
            n_fail++; $display("FAIL reset_idle_stable: got %b want %b", w_outs, 11'h0);
        end
        nxt();
    endtask

    task automatic test_nominal();
        logic [63:0] v_wea, v_inca, v_rdy, v_clra, v_clrb, v_web, v_incb, v_alu, v_done, v_busy;
        {v_wea, v_inca, v_rdy, v_clra, v_clrb} = '0;
        {v_web, v_incb, v_alu, v_done, v_busy} = '0;
        wb_addr.delete();
        for (int c = 0; c <= 25; c++) begin
            start_i = (c == 0); in_valid_i = 1'b1;
            #2;
            v_wea[c] = weA_o;  v_inca[c] = incA_o; v_rdy[c] = in_ready_o;
            v_clra[c] = clrA_o; v_clrb[c] = clrB_o; v_web[c] = weB_o;
            v_incb[c] = incB_o; v_alu[c] = alu_ld_o; v_done[c] = done_o;
            v_busy[c] = busy_o;
            if (weB_o === 1'b1) wb_addr.push_back(tb_addr_b);
            nxt();
        end
        start_i = 1'b0; in_valid_i = 1'b0;
        n_cmp++;
        if (v_wea !== 64'h3FC) begin n_fail++; $display("FAIL nominal_weA: got %h want %h", v_wea, 64'h3FC); end
        n_cmp++;
        if (v_inca !== 64'h36DBFC) begin n_fail++; $display("FAIL nominal_incA: got %h want %h", v_inca, 64'h36DBFC); end
        n_cmp++;
        if (v_rdy !== 64'h3FC) begin n_fail++; $display("FAIL nominal_in_ready: got %h want %h", v_rdy, 64'h3FC); end
        n_cmp++;
        if (v_clra !== 64'h402) begin n_fail++; $display("FAIL nominal_clrA: got %h want %h", v_clra, 64'h402); end
        n_cmp++;
        if (v_clrb !== 64'h2) begin n_fail++; $display("FAIL nominal_clrB: got %h want %h", v_clrb, 64'h2); end
        n_cmp++;
        if (v_web !== 64'h492000) begin n_fail++; $display("FAIL nominal_weB: got %h want %h", v_web, 64'h492000); end
        n_cmp++;
        if (v_incb !== 64'h492000) begin n_fail++; $display("FAIL nominal_incB: got %h want %h", v_incb, 64'h492000); end
        n_cmp++;
        if (v_alu !== 64'h249000) begin n_fail++; $display("FAIL nominal_alu_ld: got %h want %h", v_alu, 64'h249000); end
        n_cmp++;
        if (v_done !== 64'h800000) begin n_fail++; $display("FAIL nominal_done: got %h want %h", v_done, 64'h800000); end
        n_cmp++;
        if (v_busy !== 64'hFFFFFE) begin n_fail++; $display("FAIL nominal_busy: got %h want %h", v_busy, 64'hFFFFFE); end
        n_cmp++;
        if (wb_addr.size() !== 4) begin n_fail++; $display("FAIL nominal_weB_count: got %0d want 4", wb_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= wb_addr.size()) begin
                n_fail++; $display("FAIL nominal_addrB[%0d]: got none want %0d", i, i);
            end else if (wb_addr[i] !== 3'(i)) begin
                n_fail++; $display("FAIL nominal_addrB[%0d]: got %0d want %0d", i, wb_addr[i], i);
            end
        end
    endtask

    task automatic test_throttled();
        logic [63:0] v_wea, v_inca, v_rdy, v_clra, v_done;
        int bad_we;
        {v_wea, v_inca, v_rdy, v_clra, v_done} = '0;
        bad_we = 0;
        for (int c = 0; c <= 31; c++) begin
            start_i = (c == 0); in_valid_i = (c % 2 == 0);
            #2;
            v_wea[c] = weA_o; v_inca[c] = incA_o; v_rdy[c] = in_ready_o;
            v_clra[c] = clrA_o; v_done[c] = done_o;
            if (!in_valid_i && (weA_o !== 1'b0)) bad_we++;
            nxt();
        end
        start_i = 1'b0; in_valid_i = 1'b0;
        n_cmp++;
        if (v_wea !== 64'h15554) begin n_fail++; $display("FAIL throttle_weA: got %h want %h", v_wea, 64'h15554); end
        n_cmp++;
        if ($countones(v_wea) !== 8) begin n_fail++; $display("FAIL throttle_weA_count: got %0d want 8", $countones(v_wea)); end
        n_cmp++;
        if (v_inca[17:0] !== 18'h15554) begin n_fail++; $display("FAIL throttle_incA: got %h want %h", v_inca[17:0], 18'h15554); end
        n_cmp++;
        if (bad_we !== 0) begin n_fail++; $display("FAIL throttle_we_in_gap: got %0d want 0", bad_we); end
        n_cmp++;
        if (v_rdy !== 64'h1FFFC) begin n_fail++; $display("FAIL throttle_in_ready: got %h want %h", v_rdy, 64'h1FFFC); end
        n_cmp++;
        if (v_clra !== 64'h20002) begin n_fail++; $display("FAIL throttle_rewind: got %h want %h", v_clra, 64'h20002); end
        n_cmp++;
        if (v_done !== 64'h40000000) begin n_fail++; $display("FAIL throttle_done: got %h want %h", v_done, 64'h40000000); end
    endtask

    task automatic test_abort();
        logic [63:0] v_alu, v_abt, v_clra, v_clrb, v_done, v_web, v_busy;
        {v_alu, v_abt, v_clra, v_clrb, v_done, v_web, v_busy} = '0;
        for (int c = 0; c <= 20; c++) begin
            start_i = (c == 0); in_valid_i = 1'b1; abort_i = (c == 15);
            #2;
            v_alu[c] = alu_ld_o; v_abt[c] = aborted_o; v_clra[c] = clrA_o;
            v_clrb[c] = clrB_o; v_done[c] = done_o; v_web[c] = weB_o;
            v_busy[c] = busy_o;
            nxt();
        end
        start_i = 1'b0; in_valid_i = 1'b0; abort_i = 1'b0;
        n_cmp++;
        if (v_alu !== 64'h9000) begin n_fail++; $display("FAIL abort_alu_ld: got %h want %h", v_alu, 64'h9000); end
        n_cmp++;
        if (v_abt !== 64'h10000) begin n_fail++; $display("FAIL abort_pulse: got %h want %h", v_abt, 64'h10000); end
        n_cmp++;
        if (v_clra !== 64'h10402) begin n_fail++; $display("FAIL abort_clrA: got %h want %h", v_clra, 64'h10402); end
        n_cmp++;
        if (v_clrb !== 64'h10002) begin n_fail++; $display("FAIL abort_clrB: got %h want %h", v_clrb, 64'h10002); end
        n_cmp++;
        if (v_done !== 64'h0) begin n_fail++; $display("FAIL abort_no_done: got %h want %h", v_done, 64'h0); end
        n_cmp++;
        if (v_web !== 64'h2000) begin n_fail++; $display("FAIL abort_weB: got %h want %h", v_web, 64'h2000); end
        n_cmp++;
        if (v_busy !== 64'h1FFFE) begin n_fail++; $display("FAIL abort_busy: got %h want %h", v_busy, 64'h1FFFE); end
    endtask

    task automatic test_start_rules();
        logic [63:0] v_wea, v_clra, v_clrb, v_done;
        logic [3:0]  v_busy, v_clr;
        {v_wea, v_clra, v_clrb, v_done} = '0;
        v_busy = '0; v_clr = '0;
        for (int c = 0; c <= 25; c++) begin
            start_i = (c == 0) || (c == 5); in_valid_i = 1'b1;
            #2;
            v_wea[c] = weA_o; v_clra[c] = clrA_o; v_clrb[c] = clrB_o; v_done[c] = done_o;
            nxt();
        end
        in_valid_i = 1'b0;
        n_cmp++;
        if (v_wea !== 64'h3FC) begin n_fail++; $display("FAIL busy_start_weA: got %h want %h", v_wea, 64'h3FC); end
        n_cmp++;
        if (v_clra !== 64'h402) begin n_fail++; $display("FAIL busy_start_clrA: got %h want %h", v_clra, 64'h402); end
        n_cmp++;
        if (v_clrb !== 64'h2) begin n_fail++; $display("FAIL busy_start_clrB: got %h want %h", v_clrb, 64'h2); end
        n_cmp++;
        if (v_done !== 64'h800000) begin n_fail++; $display("FAIL busy_start_done: got %h want %h", v_done, 64'h800000); end
        for (int c = 0; c < 4; c++) begin
            start_i = (c < 3); abort_i = (c < 3);
            #2;
            v_busy[c] = busy_o; v_clr[c] = clrA_o | clrB_o;
            nxt();
        end
        start_i = 1'b0; abort_i = 1'b0;
        n_cmp++;
        if (v_busy !== 4'h0) begin n_fail++; $display("FAIL start_abort_idle_busy: got %b want %b", v_busy, 4'h0); end
        n_cmp++;
        if (v_clr !== 4'h0) begin n_fail++; $display("FAIL start_abort_idle_clr: got %b want %b", v_clr, 4'h0); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v_wea, v_clrb, v_web, v_done, v_busy;
        logic [2:0]  exp_addr;
        {v_wea, v_clrb, v_web, v_done, v_busy} = '0;
        wb_addr.delete();
        for (int c = 0; c <= 49; c++) begin
            start_i = (c <= 24); in_valid_i = 1'b1;
            #2;
            v_wea[c] = weA_o; v_clrb[c] = clrB_o; v_web[c] = weB_o;
            v_done[c] = done_o; v_busy[c] = busy_o;
            if (weB_o === 1'b1) wb_addr.push_back(tb_addr_b);
            nxt();
        end
        start_i = 1'b0; in_valid_i = 1'b0;
        n_cmp++;
        if (v_wea !== 64'h00000003_FC0003FC) begin n_fail++; $display("FAIL b2b_weA: got %h want %h", v_wea, 64'h00000003_FC0003FC); end
        n_cmp++;
        if (v_clrb !== 64'h00000000_02000002) begin n_fail++; $display("FAIL b2b_start: got %h want %h", v_clrb, 64'h00000000_02000002); end
        n_cmp++;
        if (v_web !== 64'h00004920_00492000) begin n_fail++; $display("FAIL b2b_weB: got %h want %h", v_web, 64'h00004920_00492000); end
        n_cmp++;
        if (v_done !== 64'h00008000_00800000) begin n_fail++; $display("FAIL b2b_done: got %h want %h", v_done, 64'h00008000_00800000); end
        n_cmp++;
        if (v_busy !== 64'h0000FFFF_FEFFFFFE) begin n_fail++; $display("FAIL b2b_busy: got %h want %h", v_busy, 64'h0000FFFF_FEFFFFFE); end
        n_cmp++;
        if (wb_addr.size() !== 8) begin n_fail++; $display("FAIL b2b_weB_count: got %0d want 8", wb_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            exp_addr = 3'(i % 4);
            n_cmp++;
            if (i >= wb_addr.size()) begin
                n_fail++; $display("FAIL b2b_addrB[%0d]: got none want %0d", i, exp_addr);
            end else if (wb_addr[i] !== exp_addr) begin
                n_fail++; $display("FAIL b2b_addrB[%0d]: got %0d want %0d", i, wb_addr[i], exp_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_throttled();
        test_abort();
        test_start_rules();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_xfer_sequencer
`default_nettype wire
